// File: rtl/display_driver_7seg_if.sv
// display_driver_7seg_if
//   Groups the request/result signals of the 7-segment display driver.
//   master : drives VALUE, LOAD, MODE, BLANK_LZ; observes HEX, BUSY, DONE, OVF
//   slave  : the driver itself (inverse directions)
//   VALUE    [WIDTH]        unsigned binary value to display
//   LOAD                    single-cycle capture request
//   MODE                    0 = hexadecimal, 1 = decimal
//   BLANK_LZ                1 = blank leading zero digits
//   HEX      [7*NUM_DIGITS] active-low segments, digit k at [7k+6:7k]
//   BUSY / DONE / OVF       conversion status
interface display_driver_7seg_if #(
  parameter int NUM_DIGITS = 3,
  parameter int WIDTH      = 12
);
  logic [WIDTH-1:0]        VALUE;
  logic                    LOAD;
  logic                    MODE;
  logic                    BLANK_LZ;
  logic [7*NUM_DIGITS-1:0] HEX;
  logic                    BUSY;
  logic                    DONE;
  logic                    OVF;

  modport master (
    output VALUE, LOAD, MODE, BLANK_LZ,
    input  HEX, BUSY, DONE, OVF
  );

  modport slave (
    input  VALUE, LOAD, MODE, BLANK_LZ,
    output HEX, BUSY, DONE, OVF
  );
endinterface

// File: rtl/display_driver_7seg.sv
// display_driver_7seg
//   Converts a binary value to NUM_DIGITS active-low 7-segment digits, either
//   directly as hex nibbles (1-cycle latency) or through a bit-serial
//   double-dabble conversion to decimal (WIDTH+1 cycles latency).
//   CLK   : system clock, rising edge
//   RST_n : asynchronous active-low reset
//   bus   : display_driver_7seg_if.slave (VALUE/LOAD/MODE/BLANK_LZ in,
//           HEX/BUSY/DONE/OVF out, all outputs registered)
module display_driver_7seg #(
  parameter int NUM_DIGITS = 3,
  parameter int WIDTH      = 12
) (
  input logic                  CLK,
  input logic                  RST_n,
  display_driver_7seg_if.slave bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [63:0] DEC_LIMIT = 64'(10 ** NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               blank_q, blank_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   src;
  logic [HEX_W-1:0]   hex_render;
  logic               ovf_calc;
  logic               lz;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    case (n)
      4'h0: seg_encode = 7'h40;
      4'h1: seg_encode = 7'h79;
      4'h2: seg_encode = 7'h24;
      4'h3: seg_encode = 7'h30;
      4'h4: seg_encode = 7'h19;
      4'h5: seg_encode = 7'h12;
      4'h6: seg_encode = 7'h02;
      4'h7: seg_encode = 7'h78;
      4'h8: seg_encode = 7'h00;
      4'h9: seg_encode = 7'h10;
      4'hA: seg_encode = 7'h08;
      4'hB: seg_encode = 7'h03;
      4'hC: seg_encode = 7'h46;
      4'hD: seg_encode = 7'h21;
      4'hE: seg_encode = 7'h06;
      default: seg_encode = 7'h0E;
    endcase
  endfunction

  // Double-dabble add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Overflow and digit rendering from the latched request. The leading-zero
  // flag walks down from the top digit and clears at the first nonzero one.
  always_comb begin
    ovf_calc   = mode_q ? (64'(value_q) >= DEC_LIMIT)
                        : ((64'(value_q) >> BCD_W) != 64'd0);
    src        = mode_q ? bcd_q : BCD_W'(value_q);
    hex_render = '0;
    lz         = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (src[4*k +: 4] != 4'd0) lz = 1'b0;
      if (ovf_calc)                   hex_render[7*k +: 7] = 7'h3F;
      else if (blank_q && lz && k != 0) hex_render[7*k +: 7] = 7'h7F;
      else                            hex_render[7*k +: 7] = seg_encode(src[4*k +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.LOAD) begin
          value_d = bus.VALUE;
          shift_d = bus.VALUE;
          mode_d  = bus.MODE;
          blank_d = bus.BLANK_LZ;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = bus.MODE ? CONVERT : UPDATE;
        end
      end
      CONVERT: begin
        // Bits shifted out of the top of the BCD register are dropped;
        // such values are flagged by the overflow compare instead.
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        hex_d   = hex_render;
        ovf_d   = ovf_calc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONVERT);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      value_q <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      hex_q   <= {NUM_DIGITS{7'h40}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.HEX  = hex_q;
  assign bus.OVF  = ovf_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_display_driver_7seg.sv
// tb_display_driver_7seg
//   Directed-vector bench for display_driver_7seg with NUM_DIGITS=3,
//   WIDTH=12. Expected segment patterns are written out by hand.
module tb_display_driver_7seg;
  localparam int ND = 3;
  localparam int W  = 12;

  logic CLK = 1'b0;
  logic RST_n;
  int   checks   = 0;
  int   failures = 0;

  display_driver_7seg_if #(.NUM_DIGITS(ND), .WIDTH(W)) dif ();

  display_driver_7seg #(.NUM_DIGITS(ND), .WIDTH(W)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (dif)
  );

  always #5 CLK = ~CLK;

  function automatic logic [20:0] h3(input logic [6:0] d2, input logic [6:0] d1,
                                     input logic [6:0] d0);
    return {d2, d1, d0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse LOAD, then step until DONE or a 40-cycle bound. Optionally drive
  // a second LOAD partway through to confirm it is ignored.
  task automatic applyStimulus(input logic [W-1:0] value, input logic mode,
                               input logic blank, input int injectAt,
                               input logic [W-1:0] injectValue,
                               output int cycles, output int busyCycles);
    @(posedge CLK); #1;
    dif.VALUE    = value;
    dif.MODE     = mode;
    dif.BLANK_LZ = blank;
    dif.LOAD     = 1'b1;
    @(posedge CLK); #1;
    dif.LOAD = 1'b0;
    cycles     = 0;
    busyCycles = 0;
    while (!dif.DONE && cycles < 40) begin
      if (dif.BUSY) busyCycles++;
      if (injectAt > 0 && cycles == injectAt) begin
        dif.VALUE = injectValue;
        dif.MODE  = 1'b0;
        dif.LOAD  = 1'b1;
      end
      @(posedge CLK); #1;
      dif.LOAD = 1'b0;
      cycles++;
    end
  endtask

  task automatic runCase(input string tag, input logic [W-1:0] value,
                         input logic mode, input logic blank, input int injectAt,
                         input logic [20:0] expHex, input logic expOvf,
                         input int expCycles, input int expBusy);
    int cycles, busyCycles;
    applyStimulus(value, mode, blank, injectAt, 12'd7, cycles, busyCycles);
    checkOutput({tag, ".latency"}, 64'(cycles), 64'(expCycles));
    checkOutput({tag, ".busy_cycles"}, 64'(busyCycles), 64'(expBusy));
    checkOutput({tag, ".hex"}, 64'(dif.HEX), 64'(expHex));
    checkOutput({tag, ".ovf"}, 64'(dif.OVF), 64'(expOvf));
    @(posedge CLK); #1;
    checkOutput({tag, ".done_pulse"}, 64'(dif.DONE), 64'd0);
  endtask

  logic [20:0] dashes;
  logic [20:0] zeros;
  int          doneSeen;

  initial begin
    dashes = h3(7'h3F, 7'h3F, 7'h3F);
    zeros  = h3(7'h40, 7'h40, 7'h40);
    RST_n        = 1'b0;
    dif.LOAD     = 1'b0;
    dif.VALUE    = '0;
    dif.MODE     = 1'b0;
    dif.BLANK_LZ = 1'b0;
    #12;
    checkOutput("reset.hex",  64'(dif.HEX),  64'(zeros));
    checkOutput("reset.busy", 64'(dif.BUSY), 64'd0);
    checkOutput("reset.done", 64'(dif.DONE), 64'd0);
    checkOutput("reset.ovf",  64'(dif.OVF),  64'd0);
    @(posedge CLK); #1;
    RST_n = 1'b1;

    runCase("hex_a5f",   12'hA5F,  1'b0, 1'b0, 0, h3(7'h08, 7'h12, 7'h0E), 1'b0, 1, 0);
    runCase("dec_255",   12'd255,  1'b1, 1'b0, 0, h3(7'h24, 7'h12, 7'h12), 1'b0, 13, 12);
    runCase("dec_1000",  12'd1000, 1'b1, 1'b0, 0, dashes,                  1'b1, 13, 12);
    runCase("dec_999",   12'd999,  1'b1, 1'b0, 0, h3(7'h10, 7'h10, 7'h10), 1'b0, 13, 12);
    runCase("hex_lz7",   12'h007,  1'b0, 1'b1, 0, h3(7'h7F, 7'h7F, 7'h78), 1'b0, 1, 0);
    runCase("hex_lz0",   12'h000,  1'b0, 1'b1, 0, h3(7'h7F, 7'h7F, 7'h40), 1'b0, 1, 0);
    runCase("hex_lz0f0", 12'h0F0,  1'b0, 1'b1, 0, h3(7'h7F, 7'h0E, 7'h40), 1'b0, 1, 0);
    runCase("dec_lz7",   12'd7,    1'b1, 1'b1, 0, h3(7'h7F, 7'h7F, 7'h78), 1'b0, 13, 12);
    runCase("dec_lz_ovf", 12'd1000, 1'b1, 1'b1, 0, dashes,                 1'b1, 13, 12);
    runCase("dec_42_ign", 12'd42,  1'b1, 1'b0, 4, h3(7'h40, 7'h19, 7'h24), 1'b0, 13, 12);
    runCase("dec_4095",  12'd4095, 1'b1, 1'b0, 0, dashes,                  1'b1, 13, 12);

    // HEX and OVF must hold while VALUE changes without LOAD.
    dif.VALUE = 12'h555;
    dif.MODE  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("hold.hex", 64'(dif.HEX), 64'(dashes));
    checkOutput("hold.ovf", 64'(dif.OVF), 64'd1);

    // Abort a decimal conversion with reset partway through.
    @(posedge CLK); #1;
    dif.VALUE = 12'd255;
    dif.MODE  = 1'b1;
    dif.LOAD  = 1'b1;
    @(posedge CLK); #1;
    dif.LOAD = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("abort.busy_before", 64'(dif.BUSY), 64'd1);
    RST_n = 1'b0;
    #2;
    checkOutput("abort.hex",  64'(dif.HEX),  64'(zeros));
    checkOutput("abort.busy", 64'(dif.BUSY), 64'd0);
    checkOutput("abort.ovf",  64'(dif.OVF),  64'd0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (dif.DONE) doneSeen++;
    end
    RST_n = 1'b1;
    repeat (14) begin
      @(posedge CLK); #1;
      if (dif.DONE) doneSeen++;
    end
    checkOutput("abort.no_done", 64'(doneSeen), 64'd0);

    runCase("post_reset_hex", 12'h123, 1'b0, 1'b0, 0, h3(7'h79, 7'h24, 7'h30), 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_driver_7seg.md
DISPLAY_DRIVER_7SEG -- requirements
Module: display_driver_7seg

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 3: number of 7-segment digits driven (1..8).
REQ-002 SHALL provide parameter WIDTH, default 12: width of the binary input value (4..32).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port VALUE  input  WIDTH  unsigned binary value to display.
REQ-006 SHALL have port LOAD  input  1  single-cycle request to capture VALUE, MODE and BLANK_LZ.
REQ-007 SHALL have port MODE  input  1  0 = hexadecimal display, 1 = decimal display.
REQ-008 SHALL have port BLANK_LZ  input  1  1 = blank leading zero digits.
REQ-009 SHALL have port HEX  output  7*NUM_DIGITS  active-low segments; digit k at bits [7k+6:7k], bit0 = segment a, bit6 = segment g; digit 0 is least significant.
REQ-010 SHALL have port BUSY  output  1  high while a conversion is in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse when HEX is updated.
REQ-012 SHALL have port OVF  output  1  value not representable in NUM_DIGITS digits of the captured mode.

Function
REQ-013 Digit encoding SHALL be, for nibbles 0..F, the 7-bit values 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex); blank = 7F; dash = 3F.
REQ-014 HEX, OVF, BUSY and DONE SHALL be registered outputs; no combinational path from inputs to outputs.
REQ-015 FSM states SHALL be IDLE, CONVERT and UPDATE.
REQ-016 LOAD SHALL be accepted only in IDLE; LOAD in CONVERT or UPDATE SHALL be ignored with no effect.
REQ-017 On accepted LOAD, the block SHALL latch VALUE, MODE and BLANK_LZ, and compute OVF from the latched value.
REQ-018 Hex mode: IDLE -> UPDATE; HEX, OVF and DONE=1 SHALL appear on the edge after the LOAD edge, i.e. 1-cycle latency; BUSY stays 0.
REQ-019 Decimal mode: IDLE -> CONVERT; a sequential shift-add-3 (double-dabble) SHALL process one input bit per cycle for exactly WIDTH cycles with BUSY=1, then UPDATE; HEX and DONE=1 SHALL appear WIDTH+1 cycles after the LOAD edge.
REQ-020 UPDATE SHALL last one cycle and return to IDLE; DONE SHALL be high only in that cycle.
REQ-021 Hex OVF SHALL be 1 when any VALUE bit at or above position 4*NUM_DIGITS is 1; decimal OVF SHALL be 1 when VALUE >= 10^NUM_DIGITS.
REQ-022 When OVF=1, every digit SHALL show dash; leading-zero blanking SHALL not apply.
REQ-023 When BLANK_LZ=1 and OVF=0, every digit above the most significant nonzero digit SHALL be blank; digit 0 SHALL never be blanked.
REQ-024 HEX SHALL hold its last value between updates, independent of VALUE changes.
REQ-025 The BCD register SHALL be 4*NUM_DIGITS bits; bits shifted out of the top during conversion SHALL be discarded (covered by OVF).

Reset
REQ-026 On RST_n low, asynchronously: FSM = IDLE, BUSY=0, DONE=0, OVF=0, every HEX digit = 40 (shows "0"), latched registers cleared.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no DONE pulse; the first LOAD after release SHALL be accepted normally.

Verification
REQ-028 NUM_DIGITS=3, WIDTH=12, MODE=0, VALUE=0xA5F, LOAD pulse -> next cycle HEX digits [2,1,0] = 08,12,0E; DONE=1 for 1 cycle; BUSY never 1.
REQ-029 MODE=1, VALUE=255, LOAD -> BUSY=1 for 12 cycles; at cycle 13 digits = 24,12,12; DONE pulse; OVF=0.
REQ-030 MODE=1, VALUE=1000 -> after 13 cycles all digits = 3F, OVF=1; then MODE=1, VALUE=999 -> all digits 10, OVF=0.
REQ-031 MODE=0, BLANK_LZ=1, VALUE=0x007 -> digits = 7F,7F,78; VALUE=0 -> digits = 7F,7F,40.
REQ-032 MODE=1, VALUE=42, LOAD; second LOAD with VALUE=7 at cycle 5 -> ignored, result = 40,19,24 (BLANK_LZ=0) at cycle 13; RST_n low at cycle 6 of a further conversion -> all digits 40, BUSY=0, no DONE.
